// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a req/ack data-memory port and stalls the pipeline until done.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int DM_ADDR_W = 10,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [31:0]          mem_ALUout,
    input  logic [31:0]          mem_storedata,
    input  logic [3:0]           mem_dm_write,
    input  logic [2:0]           mem_dm_select,
    input  logic [1:0]           mem_sel_data,
    output logic                 lsu_stall,
    output logic [31:0]          load_data,
    output logic                 load_valid,
    output logic                 lsu_err,
    output logic                 dm_req,
    output logic [3:0]           dm_we,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_ack,
    input  logic [31:0]          dm_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off;
    logic [2:0]       ld_sel;
    logic             ld_op;

    logic             is_store;
    logic             is_load;
    logic             op;
    logic             misalign;
    logic             timeout_hit;
    logic [31:0]      rd_shift;
    logic [31:0]      ld_ext;
    logic             unused_addr_bits;

    // A store takes priority when both a store mask and a load writeback are presented.
    assign is_store    = |mem_dm_write;
    assign is_load     = !is_store && (mem_sel_data == 2'b01);
    assign op          = is_store || is_load;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign unused_addr_bits = ^mem_ALUout[31:DM_ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
    logic half_acc;
    logic word_acc;

    always_comb begin
        if (is_store) begin
            half_acc = (mem_dm_write == 4'b0011);
            word_acc = (mem_dm_write == 4'b1111);
        end else begin
            // funct3 x01 is a halfword; x1x (including the undefined codes) reads a full word.
            half_acc = (mem_dm_select[1:0] == 2'b01);
            word_acc = mem_dm_select[1];
        end
    end

    assign misalign = op && ((half_acc && mem_ALUout[0]) ||
                             (word_acc && (mem_ALUout[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Lane extraction of the returned word using the offset captured at issue.
    assign rd_shift = dm_rdata >> {off, 3'b000};

    always_comb begin
        unique case (ld_sel)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
            3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
            default: ld_ext = rd_shift;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        lsu_stall = 1'b0;
        dm_req    = 1'b0;
        unique case (state)
            IDLE: begin
                lsu_stall = op;
                if (op) state_nxt = misalign ? DONE : REQ;
            end
            REQ: begin
                lsu_stall = 1'b1;
                dm_req    = 1'b1;
                if (dm_ack || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: reset is synchronous, so a mid-access reset takes effect at the next edge and dm_req drops then.
    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            off        <= 2'b00;
            ld_sel     <= 3'b000;
            ld_op      <= 1'b0;
            dm_addr    <= '0;
            dm_we      <= 4'b0000;
            dm_wdata   <= 32'h0;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            lsu_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    load_data  <= 32'h0;
                    load_valid <= 1'b0;
                    lsu_err    <= 1'b0;
                    if (op) begin
                        dm_addr  <= mem_ALUout[DM_ADDR_W+1:2];
                        off      <= mem_ALUout[1:0];
                        dm_we    <= mem_dm_write << mem_ALUout[1:0];
                        dm_wdata <= mem_storedata << {mem_ALUout[1:0], 3'b000};
                        ld_sel   <= mem_dm_select;
                        ld_op    <= is_load;
                        cnt      <= '0;
                        if (misalign) begin
                            lsu_err    <= 1'b1;
                            load_valid <= is_load;
                        end
                    end
                end
                REQ: begin
                    if (dm_ack) begin
                        load_data  <= ld_op ? ld_ext : 32'h0;
                        load_valid <= ld_op;
                    end else if (timeout_hit) begin
                        load_data  <= 32'h0;
                        load_valid <= ld_op;
                        lsu_err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    load_data  <= 32'h0;
                    load_valid <= 1'b0;
                    lsu_err    <= 1'b0;
                end
                default: begin
                    load_data  <= 32'h0;
                    load_valid <= 1'b0;
                    lsu_err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: expected completions are queued at issue and checked at DONE.
module tb_mem_stage_lsu;

    localparam int DM_ADDR_W = 10;
    localparam int TIMEOUT   = 15;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic [31:0]          mem_ALUout;
    logic [31:0]          mem_storedata;
    logic [3:0]           mem_dm_write;
    logic [2:0]           mem_dm_select;
    logic [1:0]           mem_sel_data;
    logic                 lsu_stall;
    logic [31:0]          load_data;
    logic                 load_valid;
    logic                 lsu_err;
    logic                 dm_req;
    logic [3:0]           dm_we;
    logic [DM_ADDR_W-1:0] dm_addr;
    logic [31:0]          dm_wdata;
    logic                 dm_ack;
    logic [31:0]          dm_rdata;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DM_ADDR_W(DM_ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .mem_ALUout   (mem_ALUout),
        .mem_storedata(mem_storedata),
        .mem_dm_write (mem_dm_write),
        .mem_dm_select(mem_dm_select),
        .mem_sel_data (mem_sel_data),
        .lsu_stall    (lsu_stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .lsu_err      (lsu_err),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        mem_ALUout    = 32'h0;
        mem_storedata = 32'h0;
        mem_dm_write  = 4'b0000;
        mem_dm_select = 3'b000;
        mem_sel_data  = 2'b00;
        dm_ack        = 1'b0;
        dm_rdata      = 32'h0;
    endtask

    // ack_after = number of request cycles before the ack cycle; negative means never ack.
    task automatic run_op(
        input string                 tag,
        input logic [31:0]           addr,
        input logic [31:0]           sdata,
        input logic [3:0]            we,
        input logic [2:0]            sel,
        input logic [1:0]            sd,
        input int                    ack_after,
        input logic [31:0]           rdata,
        input logic [DM_ADDR_W-1:0]  e_addr,
        input logic [3:0]            e_we,
        input logic [31:0]           e_wdata,
        input logic [31:0]           e_data,
        input logic                  e_valid,
        input logic                  e_err,
        input int                    e_stall,
        input int                    e_reqs
    );
        int   cyc      = 0;
        int   stalls   = 0;
        int   reqs     = 0;
        bit   unstable = 1'b0;
        bit   done     = 1'b0;
        exp_t e;
        sb_q.push_back('{data: e_data, valid: e_valid, err: e_err});
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (cyc == 0) begin
                mem_ALUout    = addr;
                mem_storedata = sdata;
                mem_dm_write  = we;
                mem_dm_select = sel;
                mem_sel_data  = sd;
            end
            if (dm_req && ack_after >= 0 && reqs == ack_after) begin
                dm_ack   = 1'b1;
                dm_rdata = rdata;
            end else begin
                dm_ack   = 1'b0;
                dm_rdata = $urandom;
            end
            #1;
            if (lsu_stall) stalls++;
            if (dm_req) begin
                if (reqs == 0) begin
                    check({tag, " dm_addr"}, 32'(dm_addr), 32'(e_addr));
                    check({tag, " dm_we"}, 32'(dm_we), 32'(e_we));
                    check({tag, " dm_wdata"}, dm_wdata, e_wdata);
                end else if (dm_addr !== e_addr || dm_we !== e_we || dm_wdata !== e_wdata) begin
                    unstable = 1'b1;
                end
                reqs++;
            end
            if (cyc > 0 && !lsu_stall) begin
                done = 1'b1;
                check({tag, " sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check({tag, " load_data"}, load_data, e.data);
                    check({tag, " load_valid"}, 32'(load_valid), 32'(e.valid));
                    check({tag, " lsu_err"}, 32'(lsu_err), 32'(e.err));
                end
            end
            cyc++;
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " stall_cycles"}, 32'(stalls), 32'(e_stall));
        check({tag, " req_cycles"}, 32'(reqs), 32'(e_reqs));
        check({tag, " req_stable"}, 32'(unstable), 32'd0);
        // The op was still presented during DONE; it must not have been accepted.
        @(negedge clk);
        clear_inputs();
        #1;
        check({tag, " idle_req"}, 32'(dm_req), 32'd0);
        check({tag, " idle_stall"}, 32'(lsu_stall), 32'd0);
        check({tag, " idle_data"}, load_data, 32'h0);
        check({tag, " idle_valid_err"}, {30'h0, load_valid, lsu_err}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("reset dm_req", 32'(dm_req), 32'd0);
        check("reset lsu_stall", 32'(lsu_stall), 32'd0);
        check("reset load", {load_data[30:0], load_valid}, 32'h0);
        check("reset lsu_err", 32'(lsu_err), 32'd0);
        check("reset dm_fields", 32'(dm_addr) | 32'(dm_we) | dm_wdata, 32'h0);
        @(negedge clk);
        nrst = 1'b1;

        //      tag       addr          sdata         we       sel     sd     ack rdata         e_addr e_we     e_wdata       e_data        v     err   st  rq
        run_op("sw",      32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 3'b010, 2'b00, 0, 32'h0,        10'd4, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 2,  1);
        run_op("sb",      32'h0000_0013, 32'h0000_00A5, 4'b0001, 3'b000, 2'b00, 1, 32'h0,        10'd4, 4'b1000, 32'hA500_0000, 32'h0,        1'b0, 1'b0, 3,  2);
        run_op("lb",      32'h0000_0021, 32'h0,         4'b0000, 3'b000, 2'b01, 3, 32'h1234_80FF, 10'd8, 4'b0000, 32'h0,         32'hFFFF_FF80, 1'b1, 1'b0, 5,  4);
        run_op("lbu",     32'h0000_0021, 32'h0,         4'b0000, 3'b100, 2'b01, 3, 32'h1234_80FF, 10'd8, 4'b0000, 32'h0,         32'h0000_0080, 1'b1, 1'b0, 5,  4);
        run_op("lh",      32'h0000_0002, 32'h0,         4'b0000, 3'b001, 2'b01, 0, 32'h8001_0000, 10'd0, 4'b0000, 32'h0,         32'hFFFF_8001, 1'b1, 1'b0, 2,  1);
        run_op("lhu",     32'h0000_0002, 32'h0,         4'b0000, 3'b101, 2'b01, 0, 32'h8001_0000, 10'd0, 4'b0000, 32'h0,         32'h0000_8001, 1'b1, 1'b0, 2,  1);
        run_op("lw",      32'h0000_0008, 32'h0,         4'b0000, 3'b010, 2'b01, 2, 32'hCAFE_F00D, 10'd2, 4'b0000, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0, 4,  3);
        run_op("st_wins", 32'h0000_000A, 32'h1234_ABCD, 4'b0011, 3'b000, 2'b01, 0, 32'h5555_5555, 10'd2, 4'b1100, 32'hABCD_0000, 32'h0,        1'b0, 1'b0, 2,  1);
        run_op("sel110",  32'h0000_0004, 32'h0,         4'b0000, 3'b110, 2'b01, 1, 32'h89AB_CDEF, 10'd1, 4'b0000, 32'h0,         32'h89AB_CDEF, 1'b1, 1'b0, 3,  2);
`ifdef MISALIGN_TRAP_EN
        run_op("lw_mis",  32'h0000_0006, 32'h0,         4'b0000, 3'b010, 2'b01, 0, 32'h1122_3344, 10'd1, 4'b0000, 32'h0,         32'h0,        1'b1, 1'b1, 1,  0);
        run_op("sh_mis",  32'h0000_0003, 32'h0000_BEEF, 4'b0011, 3'b000, 2'b00, 0, 32'h0,        10'd0, 4'b1000, 32'hEF00_0000, 32'h0,        1'b0, 1'b1, 1,  0);
`else
        run_op("lw_off2", 32'h0000_0006, 32'h0,         4'b0000, 3'b010, 2'b01, 0, 32'h1122_3344, 10'd1, 4'b0000, 32'h0,         32'h0000_1122, 1'b1, 1'b0, 2,  1);
        run_op("sh_off3", 32'h0000_0003, 32'h0000_BEEF, 4'b0011, 3'b000, 2'b00, 0, 32'h0,        10'd0, 4'b1000, 32'hEF00_0000, 32'h0,        1'b0, 1'b0, 2,  1);
`endif
        run_op("timeout", 32'h0000_0040, 32'h0,         4'b0000, 3'b010, 2'b01, -1, 32'h0,       10'h10, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1, 16, 15);
        run_op("ack_last",32'h0000_0042, 32'h0,         4'b0000, 3'b101, 2'b01, 14, 32'hF00D_1234, 10'h10, 4'b0000, 32'h0,       32'h0000_F00D, 1'b1, 1'b0, 16, 15);

        // Reset while a load is waiting for its ack: request drops, nothing completes.
        @(negedge clk);
        mem_ALUout   = 32'h0000_0030;
        mem_dm_select = 3'b010;
        mem_sel_data = 2'b01;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid req_before", 32'(dm_req), 32'd1);
        @(negedge clk);
        nrst = 1'b0;
        clear_inputs();
        @(negedge clk);
        #1;
        check("rst_mid req_dropped", 32'(dm_req), 32'd0);
        check("rst_mid no_err", 32'(lsu_err), 32'd0);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_mid quiet", {29'h0, dm_req, load_valid, lsu_err}, 32'h0);
        end

        run_op("sw_after",32'h0000_0100, 32'h0BAD_F00D, 4'b1111, 3'b010, 2'b00, 0, 32'h0,        10'h40, 4'b1111, 32'h0BAD_F00D, 32'h0,        1'b0, 1'b0, 2,  1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit at the consuming end of the EXE/MEM pipeline register.
- Takes the MEM-stage control and data fields (ALU address, store data, byte-write mask, load-select, writeback-select) and performs the access on a data-memory port.
- The data-memory port uses a req/ack handshake and may take several cycles.
- Holds the pipeline with a stall until the access completes. Returns aligned, sign/zero-extended load data to the writeback path.

Parameters:
- DM_ADDR_W, 10, word-address width of the data-memory port (byte address bits [DM_ADDR_W+1:2]).
- TIMEOUT, 15, maximum cycles to wait for dm_ack before forcing completion with error.

Ports:
- clk  in  1  system clock, all logic on posedge.
- nrst  in  1  synchronous active-low reset.
- mem_ALUout  in  32  byte address of the access.
- mem_storedata  in  32  unaligned store data, right-justified.
- mem_dm_write  in  4  store size mask, unshifted: 0001 byte, 0011 half, 1111 word, 0000 no store.
- mem_dm_select  in  3  load type (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_sel_data  in  2  writeback source; 2'b01 = load.
- lsu_stall  out  1  hold upstream pipeline registers.
- load_data  out  32  extended load result.
- load_valid  out  1  load_data valid this cycle.
- lsu_err  out  1  one-cycle pulse: timeout (or misalignment, see feature).
- dm_req  out  1  memory request.
- dm_we  out  4  shifted byte enables; 0000 = read.
- dm_addr  out  DM_ADDR_W  word address.
- dm_wdata  out  32  lane-aligned store data.
- dm_ack  in  1  memory acknowledge; dm_rdata valid when high.
- dm_rdata  in  32  read word.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-access drops dm_req the next cycle and discards the access; no completion or error pulse.
- op = (mem_dm_write != 0) or (mem_sel_data == 2'b01). If both are true, the store wins.
- States: IDLE, REQ, DONE.
- IDLE:
  - lsu_stall = op (combinational).
  - On op: register dm_addr = mem_ALUout[DM_ADDR_W+1:2], off = mem_ALUout[1:0], dm_we = mem_dm_write << off, dm_wdata = mem_storedata << (8*off), load type; clear counter; go to REQ.
  - For a load, dm_we = 0000.
- REQ:
  - dm_req = 1 and lsu_stall = 1. Request fields are stable while dm_req is high.
  - On dm_ack: capture dm_rdata, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack: go to DONE with lsu_err pulsed in DONE and load_data = 0.
  - An ack arriving in the same cycle as the timeout wins (normal completion, no error).
- DONE:
  - dm_req = 0, lsu_stall = 0, load_valid = 1 for loads.
  - Next state IDLE. An op presented in the DONE cycle is ignored; the pipeline advances and the new op is seen in IDLE next cycle.
- Minimum latency: op at cycle 0, dm_req at 1, ack at 1, DONE at 2. lsu_stall is high in cycles 0-1.
- Load extraction: byte = rdata >> (8*off) [7:0]; half = rdata >> (8*off) [15:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW = rdata.
- load_data and load_valid are registered and hold only during DONE. load_data returns to 0 in IDLE.
- Offsets that exceed the lane (half at off=3, word at off!=0): mask and data shift with truncation. Upper lanes are dropped.
- Undefined dm_select codes (011, 110, 111) are treated as LW.

Optional Feature:
- MISALIGN_TRAP_EN.
- Defined: an op with a half access at off[0]=1, or a word access at off!=0, is detected in IDLE. It skips REQ (no dm_req), goes straight to DONE, pulses lsu_err, and gives load_data = 0. lsu_stall is high for 1 cycle.
- Undefined: no check; truncating behaviour as above.

Test Plan:
- SW 0xDEADBEEF at addr 0x0000_0010, ack same cycle as req -> dm_addr=4, dm_we=1111, dm_wdata=0xDEADBEEF; lsu_stall high exactly 2 cycles.
- SB 0x000000A5 at addr 0x13 -> dm_we=1000, dm_wdata=0xA5000000, dm_addr=4.
- LB and LBU at addr 0x21, dm_rdata=0x1234_80FF, ack after 3 cycles -> load_data 0xFFFFFF80 (LB) and 0x00000080 (LBU). load_valid 1 cycle; lsu_stall high 5 cycles.
- LH at 0x02, rdata=0x8001_0000 -> 0xFFFF8001. LHU at 0x02 -> 0x00008001.
- Load with no ack, TIMEOUT=15 -> dm_req high 15 cycles, then lsu_err pulse, load_data=0, back to IDLE. Separately: nrst low during REQ -> dm_req 0 next cycle, no err.
- With MISALIGN_TRAP_EN, LW at 0x06 -> no dm_req, lsu_err pulse 1 cycle later, load_data=0. Without the macro: dm_req issued, load_data = rdata >> 16.
